// File: rtl/irq_timer_ctrl_pkg.sv
// Shared definitions for the memory-mapped timer / interrupt sequencer:
// register word offsets, TCON bit positions, FSM states and the IRQ PCSrc code.
package irq_timer_ctrl_pkg;

  // Word offsets from BASE_ADDR (byte offsets 0x0, 0x4, 0x8)
  localparam logic [29:0] OffTh   = 30'd0;
  localparam logic [29:0] OffTl   = 30'd1;
  localparam logic [29:0] OffTcon = 30'd2;

  localparam int unsigned TconEn = 0;
  localparam int unsigned TconIe = 1;
  localparam int unsigned TconSt = 2;

  // PCSrc selection the pipeline uses when it takes the interrupt
  localparam logic [2:0] PcSrcIrq = 3'b100;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StService = 2'd2
  } irq_state_e;

  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/irq_timer_ctrl_counter.sv
// TH/TL reload counter: TL counts up while enabled and reloads from TH instead of
// wrapping to zero; wrap_o marks the reload cycle. Software writes override counting.
module timer_reload_counter #(
  parameter logic [31:0] ThRst = 32'h0,
  parameter logic [31:0] TlRst = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic        wrap_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;

  assign wrap_o = en_i && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d = th_we_i ? wdata_i : th_q;
    tl_d = tl_q;
    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (wrap_o) begin
      tl_d = th_q;
    end else if (en_i) begin
      tl_d = tl_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      th_q <= ThRst;
      tl_q <= TlRst;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
    end
  end

  assign th_o = th_q;
  assign tl_o = tl_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped timer with an interrupt sequencer: holds irq until the pipeline
// acknowledges it and blocks re-entry until software clears TCON.ST.
module irq_timer_ctrl
  import irq_timer_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] TH_RST    = 32'h0,
  parameter logic [31:0] TL_RST    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        kernel,
  input  logic        irq_ack,
  output logic        irq
);

  localparam logic [29:0] BaseWord = BASE_ADDR[31:2];

  logic        sel_th, sel_tl, sel_tcon;
  logic        tcon_we, wrap, set_st;
  logic        en_q, en_d, ie_q, ie_d, st_q, st_d;
  logic [31:0] th, tl;
  logic [31:0] tcon;
  logic        unused_addr_lo;
  irq_state_e  state_q, state_d;

  assign unused_addr_lo = ^addr[1:0];

  assign sel_th   = word_addr(addr) == BaseWord + OffTh;
  assign sel_tl   = word_addr(addr) == BaseWord + OffTl;
  assign sel_tcon = word_addr(addr) == BaseWord + OffTcon;
  assign hit      = sel_th || sel_tl || sel_tcon;
  assign tcon_we  = mem_write && sel_tcon;

  timer_reload_counter #(
    .ThRst(TH_RST),
    .TlRst(TL_RST)
  ) u_counter (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (en_q),
    .th_we_i(mem_write && sel_th),
    .tl_we_i(mem_write && sel_tl),
    .wdata_i(wdata),
    .th_o   (th),
    .tl_o   (tl),
    .wrap_o (wrap)
  );

  // A hardware ST set beats a same-cycle software clear so no interrupt is lost
  assign set_st = wrap && ie_q;

  always_comb begin
    en_d = tcon_we ? wdata[TconEn] : en_q;
    ie_d = tcon_we ? wdata[TconIe] : ie_q;
    st_d = set_st || (tcon_we ? wdata[TconSt] : st_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (st_q && ie_q) state_d = StPending;
      end
      StPending: begin
        if (!ie_q || !st_q) state_d = StIdle;
        else if (irq_ack)   state_d = StService;
      end
      StService: begin
        if (!st_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      st_q    <= 1'b0;
      state_q <= StIdle;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      st_q    <= st_d;
      state_q <= state_d;
    end
  end

  // Mask is combinational so irq drops in the very cycle the ack is seen
  assign irq = (state_q == StPending) && !kernel && !irq_ack;

  assign tcon = {29'd0, st_q, ie_q, en_q};

  always_comb begin
    rdata = 32'd0;
    if (mem_read) begin
      if (sel_th)        rdata = th;
      else if (sel_tl)   rdata = tl;
      else if (sel_tcon) rdata = tcon;
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: stimulus queues expected values per cycle and a
// negedge monitor pops and compares them against rdata/hit/irq.
module tb_irq_timer_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk, reset, mem_read, mem_write, kernel, irq_ack;
  logic [31:0] addr, wdata, rdata;
  logic        hit, irq;

  irq_timer_ctrl #(
    .BASE_ADDR(BASE),
    .TH_RST   (32'h0),
    .TL_RST   (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wdata    (wdata),
    .rdata    (rdata),
    .hit      (hit),
    .kernel   (kernel),
    .irq_ack  (irq_ack),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {KRdata, KHit, KIrq} kind_e;
  typedef struct {
    int unsigned cyc;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void push(input kind_e k, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endfunction

  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      case (m_e.kind)
        KRdata:  m_act = rdata;
        KHit:    m_act = {31'd0, hit};
        default: m_act = {31'd0, irq};
      endcase
      n_checks++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", m_e.name, m_act, m_e.val, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    irq_ack   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string n);
    addr     = a;
    mem_read = 1'b1;
    push(KRdata, exp, n);
    push(KHit, 32'd1, {n, "_hit"});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    step();
  endtask

  task automatic chk_irq(input logic v, input string n);
    push(KIrq, {31'd0, v}, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    kernel = 1'b0; irq_ack = 1'b0;
    step(); step();
    reset = 1'b1;

    // Reset state
    rd(BASE, 32'h0, "rst_th"); chk_irq(1'b0, "rst_irq"); step();
    rd(BASE + 4, 32'h0, "rst_tl"); step();
    rd(BASE + 8, 32'h0, "rst_tcon"); step();

    // Reload sequence
    wr(BASE, 32'hFFFF_FFFD);
    wr(BASE + 4, 32'hFFFF_FFFE);
    wr(BASE + 8, 32'h3);
    rd(BASE + 4, 32'hFFFF_FFFE, "tl_start"); chk_irq(1'b0, "irq_idle"); step();
    rd(BASE + 4, 32'hFFFF_FFFF, "tl_max"); step();
    rd(BASE + 4, 32'hFFFF_FFFD, "tl_reload"); chk_irq(1'b0, "irq_latency"); step();
    rd(BASE + 4, 32'hFFFF_FFFE, "tl_after"); chk_irq(1'b1, "irq_up"); step();
    rd(BASE + 8, 32'h7, "st_set"); step();

    // Handshake, with counting stopped
    chk_irq(1'b1, "irq_hold"); wr(BASE + 8, 32'h6);
    rd(BASE + 8, 32'h6, "tcon_stop"); chk_irq(1'b1, "irq_pend"); step();
    wr(BASE + 4, 32'hFFFF_FFFF);
    irq_ack = 1'b1; chk_irq(1'b0, "ack_same_cycle"); step();
    irq_ack = 1'b1; chk_irq(1'b0, "service_ack_ignored"); rd(BASE + 8, 32'h6, "tcon_svc"); step();
    chk_irq(1'b0, "service"); wr(BASE + 8, 32'h3);
    rd(BASE + 8, 32'h3, "st_clear"); chk_irq(1'b0, "irq_cleared"); step();
    rd(BASE + 8, 32'h7, "rewrap_st"); chk_irq(1'b0, "idle_before_pend"); step();
    chk_irq(1'b1, "irq_again"); step();

    // Kernel mask holds the request
    for (int i = 0; i < 5; i++) begin
      kernel = 1'b1;
      rd(BASE + 8, 32'h7, "kmask_tcon"); chk_irq(1'b0, "kmask_irq"); step();
    end
    kernel = 1'b0; chk_irq(1'b1, "kunmask"); step();

    // Collisions
    wr(BASE + 8, 32'h0);
    wr(BASE + 4, 32'hFFFF_FFFE);
    wr(BASE + 8, 32'h3);
    rd(BASE + 4, 32'hFFFF_FFFE, "col_pre"); chk_irq(1'b0, "col_idle"); step();
    wr(BASE + 8, 32'h3);
    rd(BASE + 8, 32'h7, "col_hw_st_wins"); step();
    chk_irq(1'b1, "col_irq"); wr(BASE + 4, 32'h5);
    rd(BASE + 4, 32'h5, "col_tl_write_wins"); step();
    rd(BASE + 4, 32'h6, "col_tl_inc"); step();

    // Decode
    addr = BASE + 12; mem_read = 1'b1;
    push(KRdata, 32'h0, "miss_hi_rdata"); push(KHit, 32'h0, "miss_hi_hit"); step();
    addr = BASE - 4; mem_read = 1'b1;
    push(KRdata, 32'h0, "miss_lo_rdata"); push(KHit, 32'h0, "miss_lo_hit"); step();
    addr = BASE + 4; mem_read = 1'b0;
    push(KRdata, 32'h0, "noread_rdata"); push(KHit, 32'h1, "noread_hit"); step();
    wr(BASE + 9, 32'h2);
    rd(BASE + 8, 32'h2, "unaligned_tcon"); step();
    rd(BASE + 4, 32'hB, "tl_frozen"); step();

    // Reset while pending
    wr(BASE + 8, 32'h6);
    chk_irq(1'b0, "pre_pend"); step();
    chk_irq(1'b1, "pend_before_rst"); reset = 1'b0; step();
    reset = 1'b1; chk_irq(1'b0, "rst_mid_irq"); rd(BASE + 8, 32'h0, "rst_mid_tcon"); step();
    chk_irq(1'b0, "rst_mid_idle"); rd(BASE, 32'h0, "rst_mid_th"); step();

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
